// File: rtl/tpu_pkg.sv
// Shared constants for the TPU operand loader: FSM state encoding and the
// beats-per-operand helper used by the bank/address counter.
package tpu_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD_W = 3'd1;
    localparam logic [2:0] ST_LOAD_D = 3'd2;
    localparam logic [2:0] ST_START  = 3'd3;
    localparam logic [2:0] ST_ERROR  = 3'd4;

    function automatic int beats_per_operand(input int addr_max, input int queue_count);
        return (addr_max + 1) * queue_count;
    endfunction

    localparam int BEATS_PER_OPERAND = beats_per_operand(127, 2);

endpackage

// File: rtl/loader_addr_cnt.sv
// Bank-minor / address-major beat counter for one operand; raises terminal_o
// on the last beat of the operand and wraps back to bank 0, address 0.
module loader_addr_cnt
    import tpu_pkg::*;
#(
    parameter int QUEUE_COUNT = 2,
    parameter int ADDR_MAX    = 127,
    parameter int ADDR_WIDTH  = 10,
    parameter int BANK_WIDTH  = 1
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  clear_i,
    input  logic                  adv_i,
    output logic [BANK_WIDTH-1:0] bank_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  terminal_o
);

    localparam int BEATS = beats_per_operand(ADDR_MAX, QUEUE_COUNT);

    logic [BANK_WIDTH-1:0] bank_q, bank_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  last_bank;

    assign last_bank  = (bank_q == BANK_WIDTH'(QUEUE_COUNT - 1));
    assign terminal_o = ((int'(addr_q) * QUEUE_COUNT + int'(bank_q)) == BEATS - 1);
    assign bank_o     = bank_q;
    assign addr_o     = addr_q;

    always_comb begin
        bank_d = bank_q;
        addr_d = addr_q;
        if (clear_i) begin
            bank_d = '0;
            addr_d = '0;
        end else if (adv_i) begin
            if (terminal_o) begin
                bank_d = '0;
                addr_d = '0;
            end else if (last_bank) begin
                bank_d = '0;
                addr_d = addr_q + ADDR_WIDTH'(1);
            end else begin
                bank_d = bank_q + BANK_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            bank_q <= '0;
            addr_q <= '0;
        end else begin
            bank_q <= bank_d;
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/tpu_loader.sv
// Streams a weight operand then a data operand into per-bank SRAM write ports,
// checks in_last framing, and pulses tpu_start once both operands are written.
module tpu_loader
    import tpu_pkg::*;
#(
    parameter int ARRAY_SIZE      = 8,
    parameter int SRAM_DATA_WIDTH = 32,
    parameter int QUEUE_COUNT     = (ARRAY_SIZE + 3) / 4,
    parameter int SRAM_ADDR_WIDTH = 10,
    parameter int ADDR_MAX        = 127
) (
    input  logic                                   clk,
    input  logic                                   srst,
    input  logic                                   load_start,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [SRAM_DATA_WIDTH-1:0]             in_data,
    input  logic                                   in_last,
    output logic [QUEUE_COUNT-1:0]                 sram_write_enable_w,
    output logic [QUEUE_COUNT*SRAM_ADDR_WIDTH-1:0] sram_waddr_w_packed,
    output logic [QUEUE_COUNT*SRAM_DATA_WIDTH-1:0] sram_wdata_w_packed,
    output logic [QUEUE_COUNT-1:0]                 sram_write_enable_d,
    output logic [QUEUE_COUNT*SRAM_ADDR_WIDTH-1:0] sram_waddr_d_packed,
    output logic [QUEUE_COUNT*SRAM_DATA_WIDTH-1:0] sram_wdata_d_packed,
    output logic                                   tpu_start,
    output logic                                   load_busy,
    output logic                                   load_error
);

    localparam int AW = SRAM_ADDR_WIDTH;
    localparam int DW = SRAM_DATA_WIDTH;
    localparam int BW = (QUEUE_COUNT > 1) ? $clog2(QUEUE_COUNT) : 1;

    logic [2:0]             state_q, state_d;
    logic                   accept, cnt_clear, terminal, tpu_start_q;
    logic [BW-1:0]          bank;
    logic [AW-1:0]          addr;
    logic [QUEUE_COUNT-1:0] bank_sel;

    logic [QUEUE_COUNT-1:0]    we_w_q, we_d_q;
    logic [QUEUE_COUNT*AW-1:0] waddr_w_q, waddr_d_q;
    logic [QUEUE_COUNT*DW-1:0] wdata_w_q, wdata_d_q;

    assign in_ready   = (state_q == ST_LOAD_W) || (state_q == ST_LOAD_D);
    assign load_busy  = in_ready;
    assign load_error = (state_q == ST_ERROR);
    assign tpu_start  = tpu_start_q;
    assign accept     = in_valid && in_ready;
    assign cnt_clear  = (state_q == ST_IDLE) && load_start;

    loader_addr_cnt #(
        .QUEUE_COUNT (QUEUE_COUNT),
        .ADDR_MAX    (ADDR_MAX),
        .ADDR_WIDTH  (AW),
        .BANK_WIDTH  (BW)
    ) u_cnt (
        .clk        (clk),
        .srst       (srst),
        .clear_i    (cnt_clear),
        .adv_i      (accept),
        .bank_o     (bank),
        .addr_o     (addr),
        .terminal_o (terminal)
    );

    generate
        for (genvar gi = 0; gi < QUEUE_COUNT; gi++) begin : g_sel
            assign bank_sel[gi] = accept && (bank == BW'(gi));
        end
    endgenerate

    // Any in_last other than on the final data beat is a framing error, as is
    // a final data beat without in_last; the offending beat is still written.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (load_start) state_d = ST_LOAD_W;
            ST_LOAD_W: begin
                if (accept) begin
                    if (in_last)       state_d = ST_ERROR;
                    else if (terminal) state_d = ST_LOAD_D;
                end
            end
            ST_LOAD_D: begin
                if (accept) begin
                    if (terminal)     state_d = in_last ? ST_START : ST_ERROR;
                    else if (in_last) state_d = ST_ERROR;
                end
            end
            ST_START:  state_d = ST_IDLE;
            ST_ERROR:  state_d = ST_ERROR;
            default:   state_d = ST_IDLE;
        endcase
    end

    // tpu_start is the registered image of START so that it lands one cycle
    // after the final data write becomes visible on the SRAM port.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q     <= ST_IDLE;
            tpu_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tpu_start_q <= (state_q == ST_START);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            we_w_q    <= '0;
            we_d_q    <= '0;
            waddr_w_q <= '0;
            waddr_d_q <= '0;
            wdata_w_q <= '0;
            wdata_d_q <= '0;
        end else begin
            we_w_q <= (state_q == ST_LOAD_W) ? bank_sel : '0;
            we_d_q <= (state_q == ST_LOAD_D) ? bank_sel : '0;
            for (int q = 0; q < QUEUE_COUNT; q++) begin
                if (bank_sel[q]) begin
                    if (state_q == ST_LOAD_W) begin
                        waddr_w_q[q*AW +: AW] <= addr;
                        wdata_w_q[q*DW +: DW] <= in_data;
                    end else begin
                        waddr_d_q[q*AW +: AW] <= addr;
                        wdata_d_q[q*DW +: DW] <= in_data;
                    end
                end
            end
        end
    end

    assign sram_write_enable_w = we_w_q;
    assign sram_waddr_w_packed = waddr_w_q;
    assign sram_wdata_w_packed = wdata_w_q;
    assign sram_write_enable_d = we_d_q;
    assign sram_waddr_d_packed = waddr_d_q;
    assign sram_wdata_d_packed = wdata_d_q;

endmodule

// File: tb/tb_tpu_loader.sv
// Self-checking bench for tpu_loader: randomized valid gaps, framing errors and
// mid-load reset, checked against a beat-index write model and a start-time model.
module tb_tpu_loader;

    localparam int AS   = 8;
    localparam int DW   = 32;
    localparam int QC   = (AS + 3) / 4;
    localparam int AW   = 10;
    localparam int AMAX = 127;
    localparam int N    = (AMAX + 1) * QC;

    logic              clk = 1'b0;
    logic              srst, load_start, in_valid, in_last;
    logic              in_ready, tpu_start, load_busy, load_error;
    logic [DW-1:0]     in_data;
    logic [QC-1:0]     we_w, we_d;
    logic [QC*AW-1:0]  waddr_w, waddr_d;
    logic [QC*DW-1:0]  wdata_w, wdata_d;

    tpu_loader #(
        .ARRAY_SIZE      (AS),
        .SRAM_DATA_WIDTH (DW),
        .QUEUE_COUNT     (QC),
        .SRAM_ADDR_WIDTH (AW),
        .ADDR_MAX        (AMAX)
    ) dut (
        .clk                 (clk),
        .srst                (srst),
        .load_start          (load_start),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .in_data             (in_data),
        .in_last             (in_last),
        .sram_write_enable_w (we_w),
        .sram_waddr_w_packed (waddr_w),
        .sram_wdata_w_packed (wdata_w),
        .sram_write_enable_d (we_d),
        .sram_waddr_d_packed (waddr_d),
        .sram_wdata_d_packed (wdata_d),
        .tpu_start           (tpu_start),
        .load_busy           (load_busy),
        .load_error          (load_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_d;
        int bank;
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    int  start_cyc[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: beat i of a load goes to operand i/N, bank (i%N)%QC,
    // address (i%N)/QC, carrying the beat's data word.
    function automatic wr_t model_beat(input int i, input int data);
        wr_t e;
        e.is_d = (i >= N);
        e.bank = (i % N) % QC;
        e.addr = (i % N) / QC;
        e.data = data;
        return e;
    endfunction

    task automatic check_write(input bit is_d, input int q);
        wr_t e;
        int  a, d;
        a = is_d ? int'(waddr_d[q*AW +: AW]) : int'(waddr_w[q*AW +: AW]);
        d = is_d ? int'(wdata_d[q*DW +: DW]) : int'(wdata_w[q*DW +: DW]);
        if (exp_q.size() == 0) begin
            chk("unexpected_write", 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk("wr_operand", is_d, e.is_d);
            chk("wr_bank", q, e.bank);
            chk("wr_addr", a, e.addr);
            chk("wr_data", d, e.data);
            $display("write %s bank %0d addr %0d data %0d", is_d ? "D" : "W", q, a, d);
        end
    endtask

    always @(negedge clk) begin
        int nw;
        nw = $countones({we_w, we_d});
        if (nw > 1) chk("single_write", nw, 1);
        for (int q = 0; q < QC; q++) begin
            if (we_w[q] === 1'b1) check_write(1'b0, q);
            if (we_d[q] === 1'b1) check_write(1'b1, q);
        end
        if (tpu_start === 1'b1) start_cyc.push_back(cyc);
    end

    task automatic check_zero(input string tag);
        @(negedge clk);
        chk({tag, "_we"}, {we_w, we_d}, '0);
        chk({tag, "_addr"}, {waddr_w, waddr_d}, '0);
        chk({tag, "_data"}, {wdata_w, wdata_d}, '0);
        chk({tag, "_flags"}, {tpu_start, load_busy, load_error, in_ready}, 4'b0000);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        srst = 1'b1; load_start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        repeat (2) @(posedge clk);
        #1 srst = 1'b0;
    endtask

    // last_beat: beat carrying in_last (-1 for none); reset_at: beat index at
    // which srst replaces the beat (-1 for none); ls_at: beat at which a stray
    // load_start is pulsed (-1 for none).
    task automatic run_load(input string name, input int last_beat, input bit gaps,
                            input int reset_at, input int ls_at);
        int i = 0;
        int budget = 6000;
        int outcome = 0;   // 0 success, 1 framing error, 2 reset abort
        int final_c = -1;
        bit ls_done = 0;
        bit done = 0;
        start_cyc.delete();
        @(posedge clk); #1 load_start = 1'b1;
        @(posedge clk); #1 load_start = 1'b0;
        while (!done && budget > 0) begin
            budget--;
            if (i == reset_at) begin
                srst = 1'b1; in_valid = 1'b1; in_data = DW'(i); in_last = 1'b0;
                @(posedge clk); #1;
                srst = 1'b0; in_valid = 1'b0;
                outcome = 2;
                done = 1;
                check_zero("abort_reset");
            end else begin
                in_valid   = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                in_data    = DW'(i);
                in_last    = (i == last_beat);
                load_start = (i == ls_at) && !ls_done;
                if (load_start) ls_done = 1;
                @(negedge clk);
                if (in_valid && in_ready) begin
                    exp_q.push_back(model_beat(i, i));
                    if (i == 10) chk("busy_mid", load_busy, 1);
                    if ((in_last && i != 2*N-1) || (i == 2*N-1 && !in_last)) begin
                        outcome = 1; done = 1;
                    end else if (i == 2*N-1) begin
                        final_c = cyc; done = 1;
                    end
                    i++;
                end
                @(posedge clk); #1;
                load_start = 1'b0;
            end
        end
        in_valid = 1'b0; in_last = 1'b0; load_start = 1'b0;
        if (budget == 0) chk("beat_budget", 0, 1);
        repeat (6) @(posedge clk);
        #1;
        chk("writes_drained", exp_q.size(), 0);
        exp_q.delete();
        case (outcome)
            0: begin
                chk("start_count", start_cyc.size(), 1);
                if (start_cyc.size() > 0) chk("start_cycle", start_cyc[0], final_c + 2);
                chk("ok_error", load_error, 0);
                chk("ok_busy", load_busy, 0);
            end
            1: begin
                chk("err_flag", load_error, 1);
                chk("err_ready", in_ready, 0);
                chk("err_start", start_cyc.size(), 0);
                load_start = 1'b1; in_valid = 1'b1;
                @(posedge clk); #1 load_start = 1'b0;
                @(negedge clk);
                chk("err_sticky", load_error, 1);
                chk("err_ready_hold", in_ready, 0);
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            default: begin
                chk("abort_start", start_cyc.size(), 0);
                chk("abort_error", load_error, 0);
            end
        endcase
        $display("load %s done: outcome %0d, beats accepted %0d", name, outcome, i);
    endtask

    initial begin
        srst = 1'b1; load_start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        #1 srst = 1'b0;
        check_zero("reset");

        run_load("full", 2*N-1, 1'b0, -1, -1);
        run_load("gaps", 2*N-1, 1'b1, -1, -1);
        run_load("stray_start", 2*N-1, 1'b0, -1, 300);
        run_load("early_last", 100, 1'b0, -1, -1);
        do_reset();
        run_load("missing_last", -1, 1'b1, -1, -1);
        do_reset();
        run_load("mid_reset", 2*N-1, 1'b0, 300, -1);
        run_load("after_reset", 2*N-1, 1'b1, -1, -1);
        run_load("rand_early", $urandom_range(0, 2*N-2), 1'b1, -1, -1);
        do_reset();
        check_zero("final_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
